// File: rtl/spart_bus_ctrl.sv
// SPART bus controller: CPU register decode, baud-rate strobe, rx ack/re-arm sequencing, tx start.
// Optional feature macro: SPART_ACK_TIMEOUT_EN (ACK-state timeout with sticky err status bit).
module spart_bus_ctrl #(
   parameter int ACK_TMO = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] bus_wdata,
   output logic [7:0] bus_rdata,
   input  logic [7:0] rx_data,
   input  logic       rda,
   input  logic       tbr,
   output logic       rx_ack,
   output logic       rx_arm,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       rate_en
);

   typedef enum logic [1:0] {ARM, IDLE, ACK} state_t;

   state_t      state;
   logic [15:0] div;
   logic [15:0] cnt;
   logic        load_pend;
   logic        err;
   logic        tmo_hit;

   logic rd_acc, wr_acc, div_wr, data_rd, data_wr, stat_rd;
   assign rd_acc  = iocs & iorw;
   assign wr_acc  = iocs & ~iorw;
   assign div_wr  = wr_acc & ioaddr[1];
   assign data_rd = rd_acc & (ioaddr == 2'b00);
   assign data_wr = wr_acc & (ioaddr == 2'b00);
   assign stat_rd = rd_acc & (ioaddr == 2'b01);

   // A divisor write suppresses the strobe, then the following cycle reloads the counter.
   assign rate_en = (div != 16'd0) && (cnt == 16'd0) && !load_pend && !div_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div       <= 16'd0;
         cnt       <= 16'd0;
         load_pend <= 1'b0;
      end else begin
         load_pend <= div_wr;
         if (div_wr) begin
            if (ioaddr[0]) div[15:8] <= bus_wdata;
            else           div[7:0]  <= bus_wdata;
         end
         if (load_pend)
            cnt <= (div == 16'd0) ? 16'd0 : div - 16'd1;
         else if (div != 16'd0 && !div_wr)
            cnt <= (cnt == 16'd0) ? div - 16'd1 : cnt - 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_rdata <= 8'h00;
      end else if (rd_acc) begin
         case (ioaddr)
            2'b00:   bus_rdata <= rx_data;
            2'b01:   bus_rdata <= {5'b0, err, tbr, rda};
            2'b10:   bus_rdata <= div[7:0];
            default: bus_rdata <= div[15:8];
         endcase
      end
   end

`ifdef SPART_ACK_TIMEOUT_EN
   logic [4:0] tmo_cnt;
   assign tmo_hit = (state == ACK) && rda && (tmo_cnt == 5'(ACK_TMO - 1));

   // err is sticky; a status read clears it, but a same-cycle timeout keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= 5'd0;
         err     <= 1'b0;
      end else begin
         if (state != ACK) tmo_cnt <= 5'd0;
         else if (rda)     tmo_cnt <= tmo_cnt + 5'd1;
         if (tmo_hit)      err <= 1'b1;
         else if (stat_rd) err <= 1'b0;
      end
   end
`else
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign err        = 1'b0;
   assign unused_tmo = ^ACK_TMO;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARM;
         rx_ack   <= 1'b0;
         rx_arm   <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         tx_start <= 1'b0;
         case (state)
            // First ARM cycle raises rx_arm; second drops it and moves on.
            ARM: begin
               rx_ack <= 1'b0;
               if (rx_arm) begin
                  rx_arm <= 1'b0;
                  state  <= IDLE;
               end else begin
                  rx_arm <= 1'b1;
               end
            end
            IDLE: begin
               rx_arm <= 1'b0;
               if (data_rd && rda) begin
                  rx_ack <= 1'b1;
                  state  <= ACK;
               end
               if (data_wr && tbr) begin
                  tx_data  <= bus_wdata;
                  tx_start <= 1'b1;
               end
            end
            ACK: begin
               if (!rda || tmo_hit) begin
                  rx_ack <= 1'b0;
                  rx_arm <= 1'b1;
                  state  <= ARM;
               end
            end
            default: begin
               rx_ack <= 1'b0;
               rx_arm <= 1'b0;
               state  <= ARM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Bench for spart_bus_ctrl: vector table, directed corner sequences, random traffic vs a cycle model.
module tb_spart_bus_ctrl;

`ifdef SPART_ACK_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int ACK_TMO = 16;

   logic       clk, rst, iocs, iorw, rda, tbr;
   logic [1:0] ioaddr;
   logic [7:0] bus_wdata, bus_rdata, rx_data, tx_data;
   logic       rx_ack, rx_arm, tx_start, rate_en;

   spart_bus_ctrl #(.ACK_TMO(ACK_TMO)) dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .rx_data(rx_data),
      .rda(rda), .tbr(tbr), .rx_ack(rx_ack), .rx_arm(rx_arm),
      .tx_start(tx_start), .tx_data(tx_data), .rate_en(rate_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: expected register outputs plus divisor/strobe bookkeeping.
   int          m_cyc, m_last_wr, m_ack_start;
   logic [15:0] m_div;
   logic [7:0]  m_rdata, m_txd;
   bit          m_ack, m_arm, m_txs, m_boot, m_err;
   bit          s_rate;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, m_cyc);
      end
   endtask

   task automatic model_reset();
      m_div = 16'h0; m_last_wr = -100000; m_rdata = 8'h0; m_txd = 8'h0;
      m_ack = 0; m_arm = 0; m_txs = 0; m_boot = 1; m_err = 0; m_ack_start = 0;
   endtask

   // Strobes come every div cycles, the first one div+1 cycles after the last divisor write.
   function automatic bit exp_rate();
      bit dw;
      int d, k;
      dw = iocs && !iorw && ioaddr[1];
      d  = int'(m_div);
      k  = m_cyc - m_last_wr;
      return !dw && d != 0 && k >= d + 1 && ((k - d - 1) % d) == 0;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_rdata", 16'(bus_rdata), 16'h0);
      chk("rst_ack",   16'(rx_ack),    16'h0);
      chk("rst_arm",   16'(rx_arm),    16'h0);
      chk("rst_txs",   16'(tx_start),  16'h0);
      chk("rst_txd",   16'(tx_data),   16'h0);
      chk("rst_rate",  16'(rate_en),   16'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One bus cycle: drive, check the combinational strobe before the edge, check registers after.
   task automatic cyc(input bit cs, input bit rw, input logic [1:0] a, input logic [7:0] wd,
                      input bit rd_a, input bit tb_r, input logic [7:0] rxd);
      bit idle, drd, dwr, srd, dw, tmo, n_arm, n_ack, n_err;
      iocs = cs; iorw = rw; ioaddr = a; bus_wdata = wd; rda = rd_a; tbr = tb_r; rx_data = rxd;
      #7;
      s_rate = rate_en;
      chk("rate_en", 16'(rate_en), 16'(exp_rate()));
      @(posedge clk);
      #1;
      drd  = cs && rw && a == 2'd0;
      dwr  = cs && !rw && a == 2'd0;
      srd  = cs && rw && a == 2'd1;
      dw   = cs && !rw && a[1];
      idle = !m_boot && !m_arm && !m_ack;
      tmo  = TMO_EN && m_ack && rd_a && (m_cyc - m_ack_start == ACK_TMO - 1);
      if (cs && rw) begin
         case (a)
            2'd0: m_rdata = rxd;
            2'd1: m_rdata = {5'b0, m_err, tb_r, rd_a};
            2'd2: m_rdata = m_div[7:0];
            default: m_rdata = m_div[15:8];
         endcase
      end
      n_err = TMO_EN && ((m_err && !srd) || tmo);
      n_arm = m_boot || (m_ack && (!rd_a || tmo));
      n_ack = idle ? (drd && rd_a) : (m_ack && rd_a && !tmo);
      if (idle && drd && rd_a) m_ack_start = m_cyc + 1;
      m_txs = idle && dwr && tb_r;
      if (m_txs) m_txd = wd;
      if (dw) begin
         if (a[0]) m_div[15:8] = wd;
         else      m_div[7:0]  = wd;
         m_last_wr = m_cyc;
      end
      m_err = n_err; m_arm = n_arm; m_ack = n_ack; m_boot = 0;
      m_cyc++;
      chk("bus_rdata", 16'(bus_rdata), 16'(m_rdata));
      chk("rx_ack",    16'(rx_ack),    16'(m_ack));
      chk("rx_arm",    16'(rx_arm),    16'(m_arm));
      chk("tx_start",  16'(tx_start),  16'(m_txs));
      chk("tx_data",   16'(tx_data),   16'(m_txd));
   endtask

   task automatic idle_cyc(input bit rd_a);
      cyc(1'b0, 1'b0, 2'd0, 8'h00, rd_a, 1'b1, 8'h00);
   endtask

   typedef struct {
      bit cs; bit rw; logic [1:0] a; logic [7:0] wd; bit rd_a; bit tb_r; logic [7:0] rxd;
      logic [7:0] e_rdata; bit e_ack; bit e_arm; bit e_txs; logic [7:0] e_txd;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int cnt, bad, last, ack_hi;
      bit r_rda;
      logic [1:0] ra;
      logic [7:0] rw_d;

      // Sequence starting right after reset: arm pulse, tx accept/drop, rx ack cycle, registers.
      tbl[0]  = '{0,0,2'd0,8'h00, 0,1,8'h00, 8'h00,0,1,0,8'h00};
      tbl[1]  = '{0,0,2'd0,8'h00, 0,1,8'h00, 8'h00,0,0,0,8'h00};
      tbl[2]  = '{1,0,2'd0,8'h5A, 0,1,8'h00, 8'h00,0,0,1,8'h5A};
      tbl[3]  = '{1,0,2'd0,8'h33, 0,0,8'h00, 8'h00,0,0,0,8'h5A};
      tbl[4]  = '{1,1,2'd0,8'h00, 1,1,8'hA5, 8'hA5,1,0,0,8'h5A};
      tbl[5]  = '{1,1,2'd0,8'h00, 1,1,8'h77, 8'h77,1,0,0,8'h5A};
      tbl[6]  = '{1,0,2'd0,8'h11, 1,1,8'h00, 8'h77,1,0,0,8'h5A};
      tbl[7]  = '{0,0,2'd0,8'h00, 0,1,8'h00, 8'h77,0,1,0,8'h5A};
      tbl[8]  = '{0,0,2'd0,8'h00, 0,1,8'h00, 8'h77,0,0,0,8'h5A};
      tbl[9]  = '{1,1,2'd1,8'h00, 1,1,8'h00, 8'h03,0,0,0,8'h5A};
      tbl[10] = '{1,0,2'd2,8'h2C, 0,1,8'h00, 8'h03,0,0,0,8'h5A};
      tbl[11] = '{1,1,2'd2,8'h00, 0,1,8'h00, 8'h2C,0,0,0,8'h5A};
      tbl[12] = '{1,1,2'd3,8'h00, 0,1,8'h00, 8'h00,0,0,0,8'h5A};

      iocs = 0; iorw = 0; ioaddr = 0; bus_wdata = 0; rda = 0; tbr = 1; rx_data = 0;
      m_cyc = 0;
      do_reset();

      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].cs, tbl[i].rw, tbl[i].a, tbl[i].wd, tbl[i].rd_a, tbl[i].tb_r, tbl[i].rxd);
         chk($sformatf("vec%0d_rdata", i), 16'(bus_rdata), 16'(tbl[i].e_rdata));
         chk($sformatf("vec%0d_ack", i),   16'(rx_ack),    16'(tbl[i].e_ack));
         chk($sformatf("vec%0d_arm", i),   16'(rx_arm),    16'(tbl[i].e_arm));
         chk($sformatf("vec%0d_txs", i),   16'(tx_start),  16'(tbl[i].e_txs));
         chk($sformatf("vec%0d_txd", i),   16'(tx_data),   16'(tbl[i].e_txd));
      end

      // Divisor 3: strobe period must stay exactly 3 over 100 cycles.
      cyc(1, 0, 2'd2, 8'h03, 0, 1, 8'h00);
      cyc(1, 0, 2'd3, 8'h00, 0, 1, 8'h00);
      cnt = 0; bad = 0; last = -1;
      for (int i = 0; i < 100; i++) begin
         idle_cyc(0);
         if (s_rate) begin
            if (last >= 0 && i - last != 3) bad++;
            last = i;
            cnt++;
         end
      end
      chk("rate_period_bad", 16'(bad), 16'd0);
      chk("rate_count", 16'(cnt), 16'd33);

      // Divisor rewritten mid-count: no strobe on the write, next strobe 3 cycles later.
      cyc(1, 0, 2'd2, 8'h10, 0, 1, 8'h00);
      for (int i = 0; i < 7; i++) idle_cyc(0);
      cyc(1, 0, 2'd2, 8'h02, 0, 1, 8'h00);
      chk("rewr_strobe_wr", 16'(s_rate), 16'd0);
      idle_cyc(0); chk("rewr_strobe_p1", 16'(s_rate), 16'd0);
      idle_cyc(0); chk("rewr_strobe_p2", 16'(s_rate), 16'd0);
      idle_cyc(0); chk("rewr_strobe_p3", 16'(s_rate), 16'd1);
      cyc(1, 0, 2'd2, 8'h00, 0, 1, 8'h00);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         idle_cyc(0);
         if (s_rate) cnt++;
      end
      chk("div0_halted", 16'(cnt), 16'd0);

      // Reset while acknowledging; afterwards exactly one re-arm pulse.
      cyc(1, 1, 2'd0, 8'h00, 1, 1, 8'h3C);
      chk("pre_rst_ack", 16'(rx_ack), 16'd1);
      idle_cyc(1);
      do_reset();
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         idle_cyc(1);
         if (rx_arm) cnt++;
      end
      chk("post_rst_arm_pulses", 16'(cnt), 16'd1);

      // rda held high after the ack: waits forever, or times out when the feature is built in.
      cyc(1, 1, 2'd0, 8'h00, 1, 1, 8'hC3);
      ack_hi = rx_ack ? 1 : 0;
      for (int i = 0; i < 99; i++) begin
         idle_cyc(1);
         if (rx_ack) ack_hi++;
      end
      chk("ack_hold_cycles", 16'(ack_hi), TMO_EN ? 16'd16 : 16'd100);
      cyc(1, 1, 2'd1, 8'h00, 1, 1, 8'h00);
      chk("status_err_1", 16'(bus_rdata), TMO_EN ? 16'h07 : 16'h03);
      cyc(1, 1, 2'd1, 8'h00, 1, 1, 8'h00);
      chk("status_err_2", 16'(bus_rdata), 16'h03);
      idle_cyc(0);
      idle_cyc(0);

      // Random bus traffic with a persistent rda level; small divisors so strobes occur.
      r_rda = 0;
      for (int i = 0; i < 3000; i++) begin
         ra = 2'($urandom_range(0, 3));
         if (ra == 2'd3)      rw_d = 8'h00;
         else if (ra == 2'd2) rw_d = 8'($urandom_range(0, 9));
         else                 rw_d = 8'($urandom);
         if ($urandom_range(0, 7) == 0) r_rda = !r_rda;
         cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), ra, rw_d,
             r_rda, ($urandom_range(0, 3) != 0), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
